approx_mult_seq_ctrl: RTL and testbench

- Sequential controller for the leading-one-based approximate multiplier datapath.
- Accepts operand pairs (A, L) over a valid/ready handshake and locates the leading one of L.
- Issues one shift-add partial product per cycle for at most KEEP bits, starting at the leading one and moving down, then drops the lower bits.
- Sits between the operand source and the product consumer, replacing the unclocked combinational stage chain with a scheduled, backpressure-aware engine.

---
 rtl/approx_mult_pkg.sv | 19 +
 rtl/lead_one_detect.sv | 26 ++
 rtl/approx_mult_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_approx_mult_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared types and constants for the sequential approximate multiplier.
// Provides the controller state enum, default sizes and index-width helper.
package approx_mult_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_KEEP  = 5;

    typedef enum logic [1:0] {
        IDLE,
        DETECT,
        ACCUM,
        DONE
    } state_t;

    function automatic int lead_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/lead_one_detect.sv
// Combinational priority encoder: index of the highest set bit of vec.
// Ports: vec (WIDTH) in; idx (leading-one index, 0 when vec==0), zero out.
module lead_one_detect
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]         vec,
    output logic [lead_w(WIDTH)-1:0] idx,
    output logic                     zero
);

    localparam int IW = lead_w(WIDTH);

    // Scan LSB to MSB so the highest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
        zero = (vec == '0);
    end

endmodule

// File: rtl/approx_mult_seq_ctrl.sv
// Sequential leading-one approximate multiplier controller (valid/ready).
// Ports: clk, rst_n, in_valid/in_ready/a/l in, out_valid/out_ready/product/
// lead_pos out, busy. Macro APPROX_ROUND_EN adds round-to-nearest cycle.
module approx_mult_seq_ctrl
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int KEEP  = DEF_KEEP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         l,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       product,
    output logic [lead_w(WIDTH)-1:0] lead_pos,
    output logic                     busy
);

    localparam int IW = lead_w(WIDTH);
    localparam int NW = $clog2(WIDTH + 2);
    localparam int PW = 2 * WIDTH;

    state_t          state;
    state_t          state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] l_q;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   prod_q;
    logic [IW-1:0]   k;
    logic [IW-1:0]   p_q;
    logic [IW-1:0]   lead_q;
    logic [NW-1:0]   n;
    logic            vld_q;

    logic [IW-1:0]   det_idx;
    logic            det_zero;
    logic [IW:0]     p1;
    logic [NW-1:0]   n_init;
    logic            rnd;

    lead_one_detect #(
        .WIDTH(WIDTH)
    ) u_lod (
        .vec (l_q),
        .idx (det_idx),
        .zero(det_zero)
    );

`ifdef APPROX_ROUND_EN
    // Position of the first dropped bit; top bit set means p < KEEP.
    logic [IW:0] rnd_pos;

    always_comb begin
        rnd_pos = {1'b0, det_idx} - (IW + 1)'(KEEP);
        rnd     = 1'b0;
        if (!rnd_pos[IW]) begin
            rnd = l_q[rnd_pos[IW-1:0]];
        end
    end
`else
    assign rnd = 1'b0;
`endif

    // Rounding reuses the normal bit step: one more cycle at k = p-KEEP.
    always_comb begin
        p1 = {1'b0, det_idx} + (IW + 1)'(1);
        if (p1 < (IW + 1)'(KEEP)) begin
            n_init = NW'(p1);
        end else begin
            n_init = NW'(KEEP);
        end
        n_init = n_init + NW'(rnd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid) state_nx = DETECT;
            DETECT:  state_nx = det_zero ? DONE : ACCUM;
            ACCUM:   if (n == NW'(1)) state_nx = DONE;
            DONE:    if (vld_q && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    assign out_valid = vld_q;
    assign product   = prod_q;
    assign lead_pos  = lead_q;

    // out_valid is registered one cycle after DONE entry, which also
    // latches the result so it stays frozen under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            l_q    <= '0;
            acc    <= '0;
            prod_q <= '0;
            k      <= '0;
            p_q    <= '0;
            lead_q <= '0;
            n      <= '0;
            vld_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
                        l_q <= l;
                    end
                end
                DETECT: begin
                    acc <= '0;
                    k   <= det_idx;
                    p_q <= det_idx;
                    n   <= n_init;
                end
                ACCUM: begin
                    if (l_q[k]) begin
                        acc <= acc + (PW'(a_q) << k);
                    end
                    k <= k - IW'(1);
                    n <= n - NW'(1);
                end
                DONE: begin
                    if (!vld_q) begin
                        vld_q  <= 1'b1;
                        prod_q <= acc;
                        lead_q <= p_q;
                    end else if (out_ready) begin
                        vld_q <= 1'b0;
                    end
                end
                default: begin
                    vld_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mult_seq_ctrl.sv
// Self-checking bench for approx_mult_seq_ctrl (WIDTH=8, KEEP=5).
// Table vectors, handshake/reset corner sequences, randomized model checks.
module tb_approx_mult_seq_ctrl;

    localparam int W = 8;
    localparam int K = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  l = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [15:0] product;
    logic [2:0]  lead_pos;

    int total = 0;
    int passed = 0;

    approx_mult_seq_ctrl #(
        .WIDTH(W),
        .KEEP (K)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .l        (l),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .lead_pos (lead_pos),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int va;
        int vl;
        int prod;
        int lp;
        int lat;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference: truncate L below p-KEEP+1 (optionally round), multiply.
    function automatic void model(input int av, input int lv,
                                  output int prod, output int lp,
                                  output int lat);
        int p;
        int ml;
        int n;
        p = 0;
        if (lv == 0) begin
            prod = 0;
            lp = 0;
            lat = 2;
            return;
        end
        for (int i = 0; i < W; i++) if (((lv >> i) & 1) != 0) p = i;
        ml = (p < K) ? lv : ((lv >> (p - K + 1)) << (p - K + 1));
        n = (p + 1 < K) ? p + 1 : K;
`ifdef APPROX_ROUND_EN
        if (p >= K && ((lv >> (p - K)) & 1) != 0) begin
            ml = ml + (1 << (p - K));
            n++;
        end
`endif
        prod = av * ml;
        lp = p;
        lat = 2 + n;
    endfunction

    task automatic start_op(input int av, input int lv);
        int c;
        c = 0;
        while (!in_ready && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (!in_ready) chk("in_ready_wait", 0, 1);
        a = 8'(av);
        l = 8'(lv);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int ep,
                              input int elp, input int elat);
        int c;
        c = 0;
        while (!out_valid && c < 60) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk({nm, "_latency"}, c, elat);
        chk({nm, "_product"}, product, ep);
        chk({nm, "_lead_pos"}, lead_pos, elp);
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, "_valid_drop"}, out_valid, 0);
        chk({nm, "_ready_back"}, in_ready, 1);
    endtask

    task automatic run_op(input string nm, input int av, input int lv,
                          input int hold);
        int ep;
        int elp;
        int elat;
        int held;
        model(av, lv, ep, elp, elat);
        start_op(av, lv);
        wait_valid(nm, ep, elp, elat);
        held = product;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({nm, "_hold"}, product, held);
        end
        handshake(nm);
    endtask

    initial begin
        int ep;
        int elp;
        int elat;
        int bad;

`ifdef APPROX_ROUND_EN
        tbl[0] = '{8'h0F, 8'hFF, 16'h0EC4, 7, 8};
        tbl[4] = '{8'hFF, 8'hFF, 16'hFB04, 7, 8};
`else
        tbl[0] = '{8'h0F, 8'hFF, 16'h0E88, 7, 7};
        tbl[4] = '{8'hFF, 8'hFF, 16'hF708, 7, 7};
`endif
        tbl[1] = '{8'hAB, 8'h00, 0, 0, 2};
        tbl[2] = '{200, 8'h03, 600, 1, 4};
        tbl[3] = '{8'hFF, 8'h80, 16'h7F80, 7, 7};
        tbl[5] = '{1, 1, 1, 0, 3};
        tbl[6] = '{8'hFF, 8'h1F, 7905, 4, 7};

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_lead_pos", lead_pos, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            start_op(tbl[i].va, tbl[i].vl);
            wait_valid($sformatf("tbl%0d", i), tbl[i].prod,
                       tbl[i].lp, tbl[i].lat);
            handshake($sformatf("tbl%0d", i));
        end

        // Backpressure with a pending second request.
        start_op(8'hFF, 8'h80);
        wait_valid("bp", 16'h7F80, 7, 7);
        a = 8'h12;
        l = 8'h34;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_product_stable", product, 16'h7F80);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_valid_held", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_valid_drop", out_valid, 0);
        chk("bp_not_accepted_yet", busy, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_accepted", busy, 1);
        model(8'h12, 8'h34, ep, elp, elat);
        wait_valid("bp2", ep, elp, elat);
        handshake("bp2");

        // Reset during the third ACCUM cycle.
        start_op(8'h0F, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_product", product, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        #3;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) bad++;
        end
        chk("mid_rst_discarded", bad, 0);
        chk("post_rst_in_ready", in_ready, 1);
        run_op("post_rst", 3, 5, 0);

        for (int i = 0; i < 150; i++) begin
            int av;
            int lv;
            av = int'($urandom_range(0, 255));
            lv = int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) lv = 0;
            if ($urandom_range(0, 7) == 0) lv = 1 << $urandom_range(0, 7);
            run_op($sformatf("rnd%0d", i), av, lv,
                   int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
